alu_issue_ctrl: RTL



---
 rtl/alu_issue_if.sv | 33 +++
 rtl/alu_issue_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// Instruction request and result strobe bundle for alu_issue_ctrl.
// The slave side is the sequencer; the master side is the instruction source.
interface alu_issue_if #(
  parameter int DW = 4,
  parameter int RW = 2
) ();
  logic          in_valid;
  logic          in_ready;
  logic          in_ld;
  logic [3:0]    in_inst;
  logic [RW-1:0] in_rd;
  logic [RW-1:0] in_rs1;
  logic [RW-1:0] in_rs2;
  logic [DW-1:0] in_imm;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [RW-1:0] res_rd;
  logic          res_err;

  modport master (
    output in_valid, in_ld, in_inst,
    output in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready,
    input  res_valid, res_data, res_rd, res_err
  );

  modport slave (
    input  in_valid, in_ld, in_inst,
    input  in_rd, in_rs1, in_rs2, in_imm,
    output in_ready,
    output res_valid, res_data, res_rd, res_err
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back sequencer in front of a 4-bit combinational ALU.
// Optional ALU_ISSUE_ZFLAG_EN adds a res_zero flag valid during write-back.
module alu_issue_ctrl #(
  parameter int DW   = 4,
  parameter int NREG = 4,
  parameter int RW   = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_issue_if.slave    bus,
  output logic [DW-1:0] op_a,
  output logic [DW-1:0] op_b,
  output logic [3:0]    alu_inst,
  input  logic [DW-1:0] alu_result
`ifdef ALU_ISSUE_ZFLAG_EN
  ,
  output logic          res_zero
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0] rf [NREG];
  logic          ld_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] imm_q;
  logic          err_q;
  logic          accept;
  logic          trap;
  logic [DW-1:0] wb_val;

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.in_ready = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = EXEC;
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Divide/modulo by zero is trapped here so the ALU's value never leaks out
  always_comb begin
    trap = !ld_q && (alu_inst == 4'b1011 || alu_inst == 4'b1100)
           && (op_b == '0);
    if (ld_q)      wb_val = imm_q;
    else if (trap) wb_val = '1;
    else           wb_val = alu_result;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      op_a         <= '0;
      op_b         <= '0;
      alu_inst     <= '0;
      ld_q         <= 1'b0;
      rd_q         <= '0;
      imm_q        <= '0;
      err_q        <= 1'b0;
      bus.res_data <= '0;
      bus.res_rd   <= '0;
    end else begin
      if (accept) begin
        op_a     <= rf[bus.in_rs1];
        op_b     <= rf[bus.in_rs2];
        alu_inst <= bus.in_inst;
        ld_q     <= bus.in_ld;
        rd_q     <= bus.in_rd;
        imm_q    <= bus.in_imm;
      end
      if (state == EXEC) begin
        bus.res_data <= wb_val;
        bus.res_rd   <= rd_q;
        err_q        <= trap;
      end
      if (state == WB) rf[bus.res_rd] <= bus.res_data;
    end
  end

  assign bus.res_valid = (state == WB);
  assign bus.res_err   = (state == WB) && err_q;

`ifdef ALU_ISSUE_ZFLAG_EN
  assign res_zero = (state == WB) && (bus.res_data == '0);
`endif

endmodule
